pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 29 ++
 rtl/pc_next_sel.sv | 79 +++++++
 rtl/pc_gen.sv | 120 ++++++++++++
 tb/tb_pc_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared types and constants for the program-counter generator.
//
// Contents:
//   state_t     : fetch FSM state (RUN / WAIT / HALT)
//   STEP_FULL   : PC increment for a full-width (32-bit) instruction
//   STEP_COMP   : PC increment for a compressed (16-bit) instruction
//   ALIGN_BITS  : number of low address bits that must be zero for a legal PC
//
// Configuration macro: PC_GEN_COMPRESSED_EN
//   undefined -> 4-byte alignment (bits[1:0] must be zero)
//   defined   -> 2-byte alignment (bit0 must be zero)
package pc_gen_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int STEP_FULL = 4;
  localparam int STEP_COMP = 2;

`ifdef PC_GEN_COMPRESSED_EN
  localparam int ALIGN_BITS = 1;
`else
  localparam int ALIGN_BITS = 2;
`endif

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel -- combinational next-PC / next-state selection.
//
// Priority: trap > redirect > stall > sequential. HALT ignores everything
// except a trap. A redirect whose target has nonzero alignment bits is
// rejected: the PC is held, the FSM goes to HALT and misalign is raised for
// the owner of the registers to capture.
//
// Ports:
//   state           : current FSM state
//   pc              : current PC
//   pc_plus         : PC + step (computed by the owner)
//   stall           : hold PC and state
//   fetch_ready     : fetch stage accepts the PC this cycle
//   redirect_valid  : branch/jump taken
//   redirect_target : branch/jump destination
//   trap_valid      : trap entry
//   trap_vector     : trap handler address (low alignment bits are dropped)
//   next_pc         : PC for the next edge
//   next_state      : FSM state for the next edge
//   misalign        : current redirect is misaligned and is being rejected
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  state_t            state,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   pc_plus,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vector,
  output logic [XLEN-1:0]   next_pc,
  output state_t            next_state,
  output logic              misalign
);

  // Mask of the address bits that must be zero in a legal PC.
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((1 << ALIGN_BITS) - 1);

  logic target_misaligned;

  assign target_misaligned = |(redirect_target & LOW_MASK);

  always_comb begin
    next_pc    = pc;
    next_state = state;
    misalign   = 1'b0;

    if (trap_valid) begin
      next_pc    = trap_vector & ~LOW_MASK;
      next_state = RUN;
    end else if (state == HALT) begin
      next_pc    = pc;
      next_state = HALT;
    end else if (redirect_valid) begin
      if (target_misaligned) begin
        misalign   = 1'b1;
        next_state = HALT;
      end else begin
        next_pc    = redirect_target;
        next_state = RUN;
      end
    end else if (stall) begin
      next_pc    = pc;
      next_state = state;
    end else if (fetch_ready) begin
      // RUN and WAIT both present a valid PC, so ready means accept here.
      next_pc    = pc_plus;
      next_state = RUN;
    end else begin
      next_pc    = pc;
      next_state = WAIT;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the instruction fetch stage.
//
// Holds the PC, the RUN/WAIT/HALT fetch FSM, the misaligned-redirect error
// capture and a saturating count of accepted fetches. Next-PC selection is
// done in pc_next_sel.
//
// Configuration macro: PC_GEN_COMPRESSED_EN
//   defined   -> adds input is_compressed; step is 2 or 4, 2-byte alignment
//   undefined -> step is always 4, 4-byte alignment
//
// Parameters:
//   XLEN         : PC / target width
//   RESET_VECTOR : PC loaded by reset
//   CNT_W        : width of fetch_count
//
// Ports:
//   clk             : clock
//   Reset           : asynchronous active-high reset
//   stall           : freeze PC with no advance
//   redirect_valid  : branch/jump taken
//   redirect_target : branch/jump destination
//   trap_valid      : trap entry (highest priority, also exits HALT)
//   trap_vector     : trap handler address
//   fetch_ready     : fetch stage accepts PC this cycle
//   is_compressed   : (PC_GEN_COMPRESSED_EN only) current instruction is 16-bit
//   fetch_valid     : PC is valid for fetch
//   PC              : current fetch address
//   PCPlus          : PC + step, combinational
//   misalign_err    : one-cycle pulse on a rejected misaligned redirect
//   bad_addr        : last rejected misaligned target
//   fetch_count     : saturating count of accepted fetches
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              CNT_W        = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vector,
  input  logic              fetch_ready,
`ifdef PC_GEN_COMPRESSED_EN
  input  logic              is_compressed,
`endif
  output logic              fetch_valid,
  output logic [XLEN-1:0]   PC,
  output logic [XLEN-1:0]   PCPlus,
  output logic              misalign_err,
  output logic [XLEN-1:0]   bad_addr,
  output logic [CNT_W-1:0]  fetch_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state;
  state_t            next_state;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   step;
  logic              misalign;
  logic              accept;

`ifdef PC_GEN_COMPRESSED_EN
  assign step = is_compressed ? XLEN'(STEP_COMP) : XLEN'(STEP_FULL);
`else
  assign step = XLEN'(STEP_FULL);
`endif

  // Modulo 2^XLEN: the carry out of the top bit is simply dropped.
  assign PCPlus = PC + step;
  assign accept = fetch_valid & fetch_ready;

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_sel (
    .state           (state),
    .pc              (PC),
    .pc_plus         (PCPlus),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .next_pc         (next_pc),
    .next_state      (next_state),
    .misalign        (misalign)
  );

  // fetch_valid is registered from next_state so it always tracks the FSM
  // (low only in HALT) without a decode after the flop.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= RUN;
      PC           <= RESET_VECTOR;
      fetch_valid  <= 1'b1;
      misalign_err <= 1'b0;
      bad_addr     <= '0;
      fetch_count  <= '0;
    end else begin
      state        <= next_state;
      PC           <= next_pc;
      fetch_valid  <= (next_state != HALT);
      misalign_err <= misalign;
      if (misalign) begin
        bad_addr <= redirect_target;
      end
      if (accept) begin
        fetch_count <= sat_inc(fetch_count);
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed testbench for pc_gen (RESET_VECTOR=0x100, CNT_W=4).
module tb_pc_gen;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              Reset;
  logic              stall;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_target;
  logic              trap_valid;
  logic [XLEN-1:0]   trap_vector;
  logic              fetch_ready;
`ifdef PC_GEN_COMPRESSED_EN
  logic              is_compressed;
`endif
  logic              fetch_valid;
  logic [XLEN-1:0]   PC;
  logic [XLEN-1:0]   PCPlus;
  logic              misalign_err;
  logic [XLEN-1:0]   bad_addr;
  logic [CNT_W-1:0]  fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0100),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .Reset           (Reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .fetch_ready     (fetch_ready),
`ifdef PC_GEN_COMPRESSED_EN
    .is_compressed   (is_compressed),
`endif
    .fetch_valid     (fetch_valid),
    .PC              (PC),
    .PCPlus          (PCPlus),
    .misalign_err    (misalign_err),
    .bad_addr        (bad_addr),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_vector     = '0;
    fetch_ready     = 1'b0;
`ifdef PC_GEN_COMPRESSED_EN
    is_compressed   = 1'b0;
`endif

    // Reset state
    #2;
    chk("rst_pc",       PC,           32'h100);
    chk("rst_fv",       fetch_valid,  32'd1);
    chk("rst_mis",      misalign_err, 32'd0);
    chk("rst_bad",      bad_addr,     32'd0);
    chk("rst_cnt",      fetch_count,  32'd0);

    @(negedge clk);
    Reset       = 1'b0;
    fetch_ready = 1'b1;
    chk("seq_pc0",      PC,           32'h100);
    chk("seq_plus0",    PCPlus,       32'h104);
    tick();
    chk("seq_pc1",      PC,           32'h104);
    tick();
    chk("seq_pc2",      PC,           32'h108);
    tick();
    chk("seq_pc3",      PC,           32'h10C);
    chk("seq_cnt3",     fetch_count,  32'd3);

    // Go to 0x8, then back-pressure for two cycles
    redirect_valid  = 1'b1;
    redirect_target = 32'h8;
    tick();
    redirect_valid  = 1'b0;
    chk("redir_pc",     PC,           32'h8);
    fetch_ready = 1'b0;
    tick();
    chk("wait1_pc",     PC,           32'h8);
    chk("wait1_fv",     fetch_valid,  32'd1);
    tick();
    chk("wait2_pc",     PC,           32'h8);
    chk("wait2_fv",     fetch_valid,  32'd1);
    fetch_ready = 1'b1;
    tick();
    chk("wait_acc_pc",  PC,           32'hC);

    // Stall holds; redirect beats stall
    stall = 1'b1;
    tick();
    chk("stall_pc",     PC,           32'hC);
    chk("stall_fv",     fetch_valid,  32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    tick();
    chk("redir_stall",  PC,           32'h20);
    redirect_valid  = 1'b0;
    stall           = 1'b0;

    // Trap beats redirect
    trap_valid      = 1'b1;
    trap_vector     = 32'h200;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    chk("trap_prio",    PC,           32'h200);
    redirect_valid  = 1'b0;

    // Trap vector low alignment bits dropped
    trap_vector = 32'h2F3;
    tick();
`ifdef PC_GEN_COMPRESSED_EN
    chk("trap_align",   PC,           32'h2F2);
`else
    chk("trap_align",   PC,           32'h2F0);
`endif
    trap_valid = 1'b0;

    // Wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid  = 1'b0;
    chk("wrap_pre",     PC,           32'hFFFF_FFFC);
    tick();
    chk("wrap_pc",      PC,           32'h0);
    tick();
    chk("wrap_next",    PC,           32'h4);

`ifdef PC_GEN_COMPRESSED_EN
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid  = 1'b0;
    is_compressed   = 1'b1;
    chk("c_plus",       PCPlus,       32'h12);
    tick();
    chk("c_pc",         PC,           32'h12);
    is_compressed   = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    tick();
    redirect_valid  = 1'b0;
    chk("c_redir_pc",   PC,           32'h42);
    chk("c_redir_mis",  misalign_err, 32'd0);
    chk("c_redir_fv",   fetch_valid,  32'd1);
`else
    // Misaligned redirect -> HALT
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    tick();
    redirect_valid  = 1'b0;
    chk("mis_pulse",    misalign_err, 32'd1);
    chk("mis_bad",      bad_addr,     32'h42);
    chk("mis_fv",       fetch_valid,  32'd0);
    chk("mis_pc",       PC,           32'h4);
    tick();
    chk("mis_pulse_end", misalign_err, 32'd0);
    chk("halt_pc",      PC,           32'h4);
    chk("halt_fv",      fetch_valid,  32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    tick();
    redirect_valid  = 1'b0;
    chk("halt_ign_pc",  PC,           32'h4);
    chk("halt_ign_fv",  fetch_valid,  32'd0);
    trap_valid  = 1'b1;
    trap_vector = 32'h300;
    tick();
    trap_valid  = 1'b0;
    chk("halt_trap_pc", PC,           32'h300);
    chk("halt_trap_fv", fetch_valid,  32'd1);

    // Reset in the same cycle a misalign pulse is showing
    redirect_valid  = 1'b1;
    redirect_target = 32'h46;
    tick();
    redirect_valid  = 1'b0;
    chk("mis2_pulse",   misalign_err, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rh_mis",       misalign_err, 32'd0);
    chk("rh_fv",        fetch_valid,  32'd1);
    chk("rh_pc",        PC,           32'h100);
    chk("rh_bad",       bad_addr,     32'd0);
    @(negedge clk);
    Reset = 1'b0;
`endif

    // Reset during WAIT abandons the held PC
    tick();
    fetch_ready = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("rw_pc",        PC,           32'h100);
    chk("rw_cnt",       fetch_count,  32'd0);
    chk("rw_fv",        fetch_valid,  32'd1);
    @(negedge clk);
    Reset       = 1'b0;
    fetch_ready = 1'b1;
    chk("rw_first_pc",  PC,           32'h100);
    tick();
    chk("rw_next_pc",   PC,           32'h104);

    // Counter saturation (CNT_W=4 -> 15)
    repeat (19) tick();
    chk("sat_pc",       PC,           32'h150);
    chk("sat_cnt",      fetch_count,  32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
